// File: rtl/block_config_lut_ctx.sv
// Multi-context LUT configuration store: NUM_CTX planes with block load, a serial
// shadow chain with explicit commit and readback, and a sticky malformed-load flag.
module block_config_lut_ctx #(
  parameter int ADDR_BITS = 4,
  parameter int MEM_SIZE  = 2**ADDR_BITS,
  parameter int CTX_BITS  = 1,
  parameter int NUM_CTX   = 2**CTX_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] addr,
  output logic                 out,
  input  logic                 comb_set,
  input  logic [MEM_SIZE-1:0]  config_in,
  input  logic [CTX_BITS-1:0]  cfg_ctx,
  input  logic                 ctx_switch,
  input  logic [CTX_BITS-1:0]  ctx_next,
  input  logic                 shift_en,
  input  logic                 shift_in,
  output logic                 shift_out,
  input  logic                 commit,
  input  logic                 readback,
  output logic                 cfg_ready,
  output logic                 cfg_err,
  input  logic                 err_clr
);

  localparam logic [ADDR_BITS:0] FULL = (ADDR_BITS+1)'(MEM_SIZE);

  logic [NUM_CTX-1:0][MEM_SIZE-1:0] mem;
  logic [MEM_SIZE-1:0]              shadow;
  logic [CTX_BITS-1:0]              active_ctx;
  logic [ADDR_BITS:0]               shift_cnt;
  logic                             err_reg;

  logic               full;
  logic               conflict;
  logic               commit_taken;
  logic               commit_write;
  logic               do_shift;
  logic               err_set;
  logic [ADDR_BITS:0] cnt_base;

  assign full      = (shift_cnt == FULL);
  assign conflict  = commit & readback;
  // A commit alongside comb_set is consumed even when the chain is short: comb_set owns the plane.
  assign commit_taken = commit & ~readback & (full | comb_set);
  assign commit_write = commit & ~readback & full & ~comb_set;
  assign do_shift     = shift_en & ~readback;
  assign cnt_base     = commit_taken ? '0 : shift_cnt;
  assign err_set      = conflict
                      | (commit & ~readback & ~full & ~comb_set)
                      | (do_shift & (cnt_base == FULL));

  assign out       = mem[active_ctx][addr];
  assign shift_out = shadow[MEM_SIZE-1];
  assign cfg_ready = full;
  assign cfg_err   = err_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else begin
      for (int i = 0; i < NUM_CTX; i++) begin
        if (cfg_ctx == CTX_BITS'(i)) begin
          if (comb_set)
            mem[i] <= config_in;
          else if (commit_write)
            mem[i] <= shadow;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow    <= '0;
      shift_cnt <= '0;
    end else if (readback && !commit) begin
      shadow    <= mem[cfg_ctx];
      shift_cnt <= '0;
    end else if (!conflict) begin
      if (do_shift) begin
        shadow    <= {shadow[MEM_SIZE-2:0], shift_in};
        shift_cnt <= (cnt_base == FULL) ? FULL : cnt_base + (ADDR_BITS+1)'(1);
      end else begin
        shift_cnt <= cnt_base;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      active_ctx <= '0;
    else if (ctx_switch)
      active_ctx <= ctx_next;
  end

  // A new error outranks a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_reg <= 1'b0;
    else if (err_set)
      err_reg <= 1'b1;
    else if (err_clr)
      err_reg <= 1'b0;
  end

endmodule

// File: tb/tb_block_config_lut_ctx.sv
// Self-checking bench for block_config_lut_ctx: expected plane contents and serial
// readback bits are queued when stimulus is driven and popped when observed.
module tb_block_config_lut_ctx;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  addr;
  logic        out;
  logic        comb_set;
  logic [15:0] config_in;
  logic [0:0]  cfg_ctx;
  logic        ctx_switch;
  logic [0:0]  ctx_next;
  logic        shift_en;
  logic        shift_in;
  logic        shift_out;
  logic        commit;
  logic        readback;
  logic        cfg_ready;
  logic        cfg_err;
  logic        err_clr;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  block_config_lut_ctx dut (
    .clk(clk), .rst(rst), .addr(addr), .out(out),
    .comb_set(comb_set), .config_in(config_in), .cfg_ctx(cfg_ctx),
    .ctx_switch(ctx_switch), .ctx_next(ctx_next),
    .shift_en(shift_en), .shift_in(shift_in), .shift_out(shift_out),
    .commit(commit), .readback(readback),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .err_clr(err_clr)
  );

  always #25 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic sb_pop(input string tag, input logic [31:0] got);
    if (exp_q.size() == 0) check({tag, "_sb_empty"}, 32'd1, 32'd0);
    else check(tag, got, exp_q.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    comb_set = 0; ctx_switch = 0; shift_en = 0; shift_in = 0;
    commit = 0; readback = 0; err_clr = 0;
  endtask

  // Shift the top n bits of d in MSB first.
  task automatic shift_word(input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      shift_en = 1; shift_in = d[15-i];
      tick();
    end
    shift_en = 0; shift_in = 0;
  endtask

  task automatic read_plane(input logic [0:0] c, output logic [15:0] v);
    ctx_switch = 1; ctx_next = c;
    tick();
    ctx_switch = 0;
    for (int a = 0; a < 16; a++) begin
      addr = 4'(a);
      #1;
      v[a] = out;
    end
  endtask

  task automatic sb_plane(input string tag, input logic [0:0] c);
    logic [15:0] v;
    read_plane(c, v);
    sb_pop(tag, {16'h0, v});
  endtask

  initial begin
    logic [15:0] rb_word;
    clear_ctl();
    addr = 0; config_in = 0; cfg_ctx = 0; ctx_next = 0;
    rst = 1;
    #1;
    check("rst_out", {31'b0, out}, 0);
    check("rst_shift_out", {31'b0, shift_out}, 0);
    check("rst_ready", {31'b0, cfg_ready}, 0);
    check("rst_err", {31'b0, cfg_err}, 0);
    tick();
    rst = 0;
    tick();

    // Block load into plane 1; plane 0 untouched
    comb_set = 1; config_in = 16'hA5C3; cfg_ctx = 1;
    tick();
    clear_ctl();
    exp_q.push_back(32'hA5C3); sb_plane("blk_plane1", 1);
    exp_q.push_back(32'h0);    sb_plane("blk_plane0", 0);

    // Full serial load and commit to plane 0
    shift_word(16'h8001, 16);
    check("ser_ready_full", {31'b0, cfg_ready}, 1);
    commit = 1; cfg_ctx = 0;
    tick();
    clear_ctl();
    check("ser_ready_after", {31'b0, cfg_ready}, 0);
    check("ser_err", {31'b0, cfg_err}, 0);
    exp_q.push_back(32'h8001); sb_plane("ser_plane0", 0);

    // Short load: commit refused
    shift_word(16'hFFFF, 15);
    check("short_ready", {31'b0, cfg_ready}, 0);
    commit = 1; cfg_ctx = 0;
    tick();
    clear_ctl();
    check("short_err", {31'b0, cfg_err}, 1);
    exp_q.push_back(32'h8001); sb_plane("short_plane0", 0);
    err_clr = 1; tick(); clear_ctl();
    check("short_err_clr", {31'b0, cfg_err}, 0);

    // Overshift, then clear racing a new error
    shift_word(16'hFFFF, 1);
    check("over_ready", {31'b0, cfg_ready}, 1);
    check("over_err_none", {31'b0, cfg_err}, 0);
    shift_word(16'hFFFF, 1);
    check("over_err", {31'b0, cfg_err}, 1);
    check("over_ready_sat", {31'b0, cfg_ready}, 1);
    err_clr = 1; shift_en = 1; shift_in = 1;
    tick(); clear_ctl();
    check("clr_vs_err", {31'b0, cfg_err}, 1);
    err_clr = 1; tick(); clear_ctl();
    check("err_clr", {31'b0, cfg_err}, 0);

    // Readback of plane 1 drains MSB first
    readback = 1; cfg_ctx = 1;
    tick();
    clear_ctl();
    check("rb_ready", {31'b0, cfg_ready}, 0);
    rb_word = 16'hA5C3;
    for (int i = 15; i >= 0; i--) exp_q.push_back({31'b0, rb_word[i]});
    for (int i = 0; i < 16; i++) begin
      sb_pop($sformatf("rb_bit%0d", i), {31'b0, shift_out});
      shift_word(16'h0000, 1);
    end
    check("rb_ready_end", {31'b0, cfg_ready}, 1);

    // comb_set + commit: config_in wins, commit consumed, no error
    comb_set = 1; config_in = 16'h1234; commit = 1; cfg_ctx = 0;
    tick();
    clear_ctl();
    check("cs_commit_err", {31'b0, cfg_err}, 0);
    check("cs_commit_ready", {31'b0, cfg_ready}, 0);
    exp_q.push_back(32'h1234); sb_plane("cs_commit_plane0", 0);

    // commit + shift: pre-shift shadow stored, count restarts at 1
    shift_word(16'h5A0F, 16);
    commit = 1; shift_en = 1; shift_in = 1; cfg_ctx = 1;
    tick();
    clear_ctl();
    check("cm_shift_err", {31'b0, cfg_err}, 0);
    shift_word(16'h0000, 14);
    check("cm_shift_cnt15", {31'b0, cfg_ready}, 0);
    shift_word(16'h0000, 1);
    check("cm_shift_cnt16", {31'b0, cfg_ready}, 1);
    exp_q.push_back(32'h5A0F); sb_plane("cm_shift_plane1", 1);

    // readback + shift: shift dropped
    readback = 1; shift_en = 1; shift_in = 1; cfg_ctx = 1;
    tick();
    clear_ctl();
    check("rb_shift_msb", {31'b0, shift_out}, 0);
    shift_word(16'h0000, 1);
    check("rb_shift_bit14", {31'b0, shift_out}, 1);
    shift_word(16'h0000, 14);
    check("rb_shift_cnt15", {31'b0, cfg_ready}, 0);
    shift_word(16'h0000, 1);
    check("rb_shift_cnt16", {31'b0, cfg_ready}, 1);

    // commit + readback: error, state held
    commit = 1; readback = 1; cfg_ctx = 0;
    tick();
    clear_ctl();
    check("cm_rb_err", {31'b0, cfg_err}, 1);
    check("cm_rb_ready", {31'b0, cfg_ready}, 1);
    exp_q.push_back(32'h1234); sb_plane("cm_rb_plane0", 0);
    err_clr = 1; tick(); clear_ctl();

    // Reset mid-operation, no clock edge
    addr = 4'd2;
    #1;
    check("pre_rst_out", {31'b0, out}, 1);
    shift_word(16'hFFFF, 5);
    commit = 1; cfg_ctx = 0;
    tick();
    clear_ctl();
    check("pre_rst_err", {31'b0, cfg_err}, 1);
    rst = 1;
    #1;
    check("mid_rst_out", {31'b0, out}, 0);
    check("mid_rst_ready", {31'b0, cfg_ready}, 0);
    check("mid_rst_shift_out", {31'b0, shift_out}, 0);
    check("mid_rst_err", {31'b0, cfg_err}, 0);
    tick();
    rst = 0;
    tick();
    exp_q.push_back(32'h0); sb_plane("post_rst_plane0", 0);
    exp_q.push_back(32'h0); sb_plane("post_rst_plane1", 1);

    if (exp_q.size() != 0) check("sb_leftover", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
